// File: rtl/eq_pkg.sv
// Shared equalizer definitions: widths, signed datapath types, output rounding.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
package eq_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int CNT_W  = 6;
  localparam int FRAC   = 15;
  localparam int TAPS   = 2 ** CNT_W;
  localparam int PROD_W = DATA_W + COEF_W;
  // Room for TAPS full-scale products, so the sum can never wrap.
  localparam int ACC_W  = PROD_W + CNT_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam acc_t RND_HALF = acc_t'(1) <<< (FRAC - 1);
  localparam acc_t SAT_MAX  = acc_t'(2 ** (DATA_W - 1) - 1);
  localparam acc_t SAT_MIN  = -acc_t'(2 ** (DATA_W - 1));

  // Round half-up, drop FRAC fraction bits, then clamp to the sample range.
  function automatic sample_t round_sat(input acc_t sum);
    acc_t r;
    r = (sum + RND_HALF) >>> FRAC;
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end
    return sample_t'(r[DATA_W-1:0]);
  endfunction

endpackage

// File: rtl/tap_delay_line.sv
// Circular sample history: one write per frame, read by tap offset behind the newest sample.
// Latency: write lands on the enabled edge; read is combinational.
// Backpressure: none; writes happen whenever wr_en_i is high.
module tap_delay_line
  import eq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  sample_t          wr_dat_i,
  input  logic [CNT_W-1:0] rd_tap_i,
  output sample_t          rd_dat_o
);

  sample_t          mem_q [TAPS];
  logic [CNT_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] wr_ptr_d;
  logic [CNT_W-1:0] rd_addr;

  assign wr_ptr_d = wr_ptr_q + CNT_W'(1);

  // Pointer to the next slot to write; after a write it sits one past the newest sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
    end else if (wr_en_i) begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is intentionally not reset; stale entries are masked by the fill count upstream.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_dat_i;
    end
  end

  // Tap k is k slots older than the newest sample (modulo wrap is free at CNT_W bits).
  assign rd_addr  = wr_ptr_q - CNT_W'(1) - rd_tap_i;
  assign rd_dat_o = mem_q[rd_addr];

endmodule

// File: rtl/fir_tap_mac.sv
// 64-tap FIR multiply-accumulate driven by the band's tap counter, one output per full sweep.
// Latency: sample_out updates on the enabled edge after tap 63 (64 enabled edges after capture).
// Backpressure: none; a skipped or repeated count abandons the frame until the next count 0.
module fir_tap_mac
  import eq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic [CNT_W-1:0]         current_count,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic signed [COEF_W-1:0] coeff_in,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     sample_valid
);

  localparam logic [CNT_W:0]   FILL_MAX = (CNT_W + 1)'(TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  acc_t             acc_q, acc_d;
  logic [CNT_W:0]   fill_q, fill_d;
  logic             frame_ok_q, frame_ok_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  sample_t          out_q, out_d;
  logic             vld_q, vld_d;

  logic    tap0;
  logic    in_seq;
  sample_t dl_rd;
  sample_t x_k;
  prod_t   prod;
  acc_t    sum;

  assign tap0 = (current_count == '0);

  tap_delay_line u_dly (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (clk_enable & tap0),
    .wr_dat_i (sample_in),
    .rd_tap_i (current_count),
    .rd_dat_o (dl_rd)
  );

  // Tap 0 bypasses the RAM; fill_q already counts this frame's sample, so taps
  // at or beyond it have never been written and must contribute nothing.
  assign x_k    = tap0 ? sample_in
                : (({1'b0, current_count} >= fill_q) ? sample_t'(0) : dl_rd);
  assign prod   = prod_t'(x_k) * prod_t'(coeff_in);
  assign sum    = acc_q + acc_t'(prod);
  assign in_seq = frame_ok_q && (current_count == exp_q);

  // Next-state for the frame sequencer: restart on count 0, accumulate in order, emit at tap 63.
  always_comb begin
    acc_d      = acc_q;
    fill_d     = fill_q;
    frame_ok_d = frame_ok_q;
    exp_d      = exp_q;
    out_d      = out_q;
    vld_d      = 1'b0;
    if (clk_enable) begin
      if (tap0) begin
        acc_d      = acc_t'(prod);
        fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + (CNT_W + 1)'(1);
        frame_ok_d = 1'b1;
        exp_d      = CNT_W'(1);
      end else if (in_seq) begin
        if (current_count == LAST_TAP) begin
          out_d      = round_sat(sum);
          vld_d      = 1'b1;
          frame_ok_d = 1'b0;
        end else begin
          acc_d = sum;
          exp_d = current_count + CNT_W'(1);
        end
      end else begin
        frame_ok_d = 1'b0;
      end
    end
  end

  // State registers; the valid pulse self-clears even while clk_enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      fill_q     <= '0;
      frame_ok_q <= 1'b0;
      exp_q      <= '0;
      out_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      frame_ok_q <= frame_ok_d;
      exp_q      <= exp_d;
      out_q      <= out_d;
      vld_q      <= vld_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = vld_q;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Scoreboard bench for fir_tap_mac: stimulus pushes hand-computed frame outputs,
// a negedge monitor pops and compares on every sample_valid.
// Covers impulse, enable gaps, fill ramp with saturation, counter restart, async reset, negative clamp.
module tb_fir_tap_mac;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_enable;
  logic [5:0]        current_count;
  logic signed [15:0] sample_in;
  logic signed [15:0] coeff_in;
  logic signed [15:0] sample_out;
  logic              sample_valid;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] exp_q [$];
  int                 coef_mode = 0;
  bit                 gap_mode  = 1'b0;
  logic signed [15:0] last_out  = '0;
  bit                 prev_vld  = 1'b0;

  fir_tap_mac dut (
    .clk           (clk),
    .rst           (rst),
    .clk_enable    (clk_enable),
    .current_count (current_count),
    .sample_in     (sample_in),
    .coeff_in      (coeff_in),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [15:0] coef_of(input int k);
    case (coef_mode)
      0:       return 16'(100 * k);
      1:       return 16'h1000;
      default: return 16'h7FFF;
    endcase
  endfunction

  // Present tap k; with gap, two disabled cycles precede the enabled one.
  task automatic tap(input int k, input logic signed [15:0] s, input bit gap);
    if (gap) begin
      repeat (2) begin
        @(posedge clk); #1;
        clk_enable = 1'b0;
      end
    end
    @(posedge clk); #1;
    clk_enable    = 1'b1;
    current_count = 6'(k);
    sample_in     = s;
    coeff_in      = coef_of(k);
  endtask

  task automatic run_frame(input logic signed [15:0] s, input int last_k, input bit gap,
                           input bit has_exp, input logic signed [15:0] e);
    if (has_exp) exp_q.push_back(e);
    for (int k = 0; k <= last_k; k++) tap(k, s, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      clk_enable = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle(3);
    rst = 1'b1;
    current_count = '0;
    #1;
    check("rst_sample_out", sample_out, 0);
    check("rst_sample_valid", sample_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: pop an expectation on every valid; valid must be one clk wide.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        prev_vld = 1'b0;
        last_out = '0;
      end else begin
        if (sample_valid === 1'b1) begin
          check("valid_width", prev_vld, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            check("sample_out", sample_out, exp_q.pop_front());
          end
          last_out = sample_out;
        end else if (gap_mode) begin
          check("hold_between_valids", sample_out, last_out);
        end
        prev_vld = (sample_valid === 1'b1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    rst = 1'b0; clk_enable = 1'b0; current_count = '0; sample_in = '0; coeff_in = '0;

    // Impulse through coefficient ramp 100*k: frame j -> 50*j, then zero.
    coef_mode = 0;
    do_reset();
    for (int j = 0; j < 66; j++)
      run_frame(j == 0 ? 16'sh4000 : 16'sh0000, 63, 1'b0, 1'b1, (j < 64) ? 16'(50 * j) : 16'sd0);

    // Same impulse with clk_enable active one cycle in three.
    do_reset();
    gap_mode = 1'b1;
    for (int j = 0; j < 10; j++)
      run_frame(j == 0 ? 16'sh4000 : 16'sh0000, 63, 1'b1, 1'b1, 16'(50 * j));
    idle(4);
    gap_mode = 1'b0;

    // Fill ramp: frame n -> (n+1)*0x200, clamps at 0x7FFF from frame 63.
    coef_mode = 1;
    do_reset();
    for (int n = 0; n < 66; n++) begin
      v = (n + 1) * 512;
      if (v > 32767) v = 32767;
      run_frame(16'sh1000, 63, 1'b0, 1'b1, 16'(v));
    end

    // Counter restart at count 30: aborted frame silent, fill jumps by two.
    do_reset();
    run_frame(16'sh1000, 63, 1'b0, 1'b1, 16'sh0200);
    run_frame(16'sh1000, 63, 1'b0, 1'b1, 16'sh0400);
    run_frame(16'sh1000, 29, 1'b0, 1'b0, 16'sh0000);
    run_frame(16'sh1000, 63, 1'b0, 1'b1, 16'sh0800);
    run_frame(16'sh1000, 63, 1'b0, 1'b1, 16'sh0A00);

    // Async reset during tap 40: outputs clear at once, refill restarts.
    do_reset();
    run_frame(16'sh1000, 63, 1'b0, 1'b1, 16'sh0200);
    run_frame(16'sh1000, 39, 1'b0, 1'b0, 16'sh0000);
    @(posedge clk); #1;
    rst = 1'b1;
    clk_enable = 1'b0;
    #1;
    check("async_rst_sample_out", sample_out, 0);
    check("async_rst_sample_valid", sample_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(16'sh1000, 63, 1'b0, 1'b1, 16'sh0200);

    // Negative full scale: frame 0 is -32767, later frames clamp to -32768.
    coef_mode = 2;
    do_reset();
    for (int n = 0; n < 65; n++)
      run_frame(16'sh8000, 63, 1'b0, 1'b1, (n == 0) ? 16'sh8001 : 16'sh8000);

    idle(5);
    check("outstanding_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
